// File: rtl/score_streamer_if.sv
// Stream interface between the score streamer (master) and the argmax
// comparator (slave): one requantized score per beat with first/last
// strobes, and the comparator's running winning index returned.
interface score_streamer_if #(
    parameter int BIT   = 8,
    parameter int IDX_W = 4
);
    logic signed [BIT-1:0] s_data;
    logic                  s_valid;
    logic                  s_first;
    logic                  s_last;
    logic [IDX_W-1:0]      s_idx;
    logic [IDX_W-1:0]      cmp_idx;

    modport master (
        output s_data,
        output s_valid,
        output s_first,
        output s_last,
        output s_idx,
        input  cmp_idx
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_first,
        input  s_last,
        input  s_idx,
        output cmp_idx
    );
endinterface

// File: rtl/score_streamer.sv
// score_streamer: holds the NUM_CLASS final accumulator scores, streams
// them requantized to the argmax comparator on start, then captures the
// winning class and offers it to the CPU over a valid/ack handshake.
// Optional feature macro: SCORE_STREAMER_SAT_EN
//   defined   -> requantized scores saturate to the BIT-bit signed range
//   undefined -> requantized scores wrap (low BIT bits of score >>> SHIFT)
module score_streamer #(
    parameter int NUM_CLASS = 10,
    parameter int ACC_BIT   = 20,
    parameter int BIT       = 8,
    parameter int IDX_W     = 4,
    parameter int SHIFT     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_addr,
    input  logic signed [ACC_BIT-1:0] wr_data,
    input  logic                      start,
    score_streamer_if.master          strm,
    output logic                      busy,
    output logic                      res_valid,
    output logic [IDX_W-1:0]          result_idx,
    input  logic                      res_ack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
    localparam logic [IDX_W:0]   NUM_IDX  = (IDX_W + 1)'(NUM_CLASS);

`ifdef SCORE_STREAMER_SAT_EN
    localparam logic signed [ACC_BIT-1:0] Q_MAX = ACC_BIT'((32'sd1 <<< (BIT - 1)) - 32'sd1);
    localparam logic signed [ACC_BIT-1:0] Q_MIN = ~Q_MAX;
`endif

    // Requantize one accumulator score to the streamed width.
    function automatic logic signed [BIT-1:0] requant(input logic signed [ACC_BIT-1:0] score);
`ifdef SCORE_STREAMER_SAT_EN
        logic signed [ACC_BIT-1:0] sh;
        sh = score >>> SHIFT;
        if (sh > Q_MAX) begin
            requant = Q_MAX[BIT-1:0];
        end else if (sh < Q_MIN) begin
            requant = Q_MIN[BIT-1:0];
        end else begin
            requant = sh[BIT-1:0];
        end
`else
        requant = BIT'(score >>> SHIFT);
`endif
    endfunction

    state_t                    state_r, state_nxt_s;
    logic [IDX_W-1:0]          beat_r, beat_nxt_s;
    logic [DRN_W-1:0]          drain_r, drain_nxt_s;
    logic signed [ACC_BIT-1:0] bank_r [NUM_CLASS];

    logic                      bank_we_s;
    logic signed [ACC_BIT-1:0] rd_score_s;

    logic signed [BIT-1:0]     s_data_r, s_data_nxt_s;
    logic                      s_valid_r, s_valid_nxt_s;
    logic                      s_first_r, s_first_nxt_s;
    logic                      s_last_r, s_last_nxt_s;
    logic [IDX_W-1:0]          s_idx_r, s_idx_nxt_s;
    logic                      busy_r, busy_nxt_s;
    logic                      res_valid_r, res_valid_nxt_s;
    logic [IDX_W-1:0]          result_idx_r, result_idx_nxt_s;

    // The bank is frozen while a run is in progress; out-of-range writes are dropped.
    assign bank_we_s = wr_en && !busy_r && ({1'b0, wr_addr} < NUM_IDX);

    // Score bank storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                bank_r[i] <= '0;
            end
        end else if (bank_we_s) begin
            bank_r[wr_addr] <= wr_data;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            beat_r       <= '0;
            drain_r      <= '0;
            s_data_r     <= '0;
            s_valid_r    <= 1'b0;
            s_first_r    <= 1'b0;
            s_last_r     <= 1'b0;
            s_idx_r      <= '0;
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            result_idx_r <= '0;
        end else begin
            state_r      <= state_nxt_s;
            beat_r       <= beat_nxt_s;
            drain_r      <= drain_nxt_s;
            s_data_r     <= s_data_nxt_s;
            s_valid_r    <= s_valid_nxt_s;
            s_first_r    <= s_first_nxt_s;
            s_last_r     <= s_last_nxt_s;
            s_idx_r      <= s_idx_nxt_s;
            busy_r       <= busy_nxt_s;
            res_valid_r  <= res_valid_nxt_s;
            result_idx_r <= result_idx_nxt_s;
        end
    end

    // Next state plus the beat and drain counters that steer it.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = '0;
        drain_nxt_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (start && !res_valid_r) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (beat_r == LAST_IDX) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_STREAM;
                    beat_nxt_s  = beat_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRN_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                    drain_nxt_s = drain_r + {{(DRN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; the beat about to be shown is
    // read here, with a same-cycle IDLE write forwarded so start+write streams
    // the new value.
    always_comb begin
        if ((state_r == ST_IDLE) && bank_we_s && (wr_addr == beat_nxt_s)) begin
            rd_score_s = wr_data;
        end else begin
            rd_score_s = bank_r[beat_nxt_s];
        end

        s_valid_nxt_s = (state_nxt_s == ST_STREAM);
        if (s_valid_nxt_s) begin
            s_data_nxt_s  = requant(rd_score_s);
            s_idx_nxt_s   = beat_nxt_s;
            s_first_nxt_s = (beat_nxt_s == '0);
            s_last_nxt_s  = (beat_nxt_s == LAST_IDX);
        end else begin
            s_data_nxt_s  = '0;
            s_idx_nxt_s   = '0;
            s_first_nxt_s = 1'b0;
            s_last_nxt_s  = 1'b0;
        end

        busy_nxt_s = (state_nxt_s != ST_IDLE);

        if ((state_r == ST_DRAIN) && (state_nxt_s == ST_IDLE)) begin
            res_valid_nxt_s  = 1'b1;
            result_idx_nxt_s = strm.cmp_idx;
        end else if (res_valid_r && res_ack) begin
            res_valid_nxt_s  = 1'b0;
            result_idx_nxt_s = result_idx_r;
        end else begin
            res_valid_nxt_s  = res_valid_r;
            result_idx_nxt_s = result_idx_r;
        end
    end

    assign strm.s_data  = s_data_r;
    assign strm.s_valid = s_valid_r;
    assign strm.s_first = s_first_r;
    assign strm.s_last  = s_last_r;
    assign strm.s_idx   = s_idx_r;
    assign busy         = busy_r;
    assign res_valid    = res_valid_r;
    assign result_idx   = result_idx_r;

endmodule

// File: tb/tb_score_streamer.sv
// Self-checking bench for score_streamer: directed scenarios plus random
// score sets, checked against a floor-division/clamp reference model and a
// behavioural argmax comparator.
module tb_score_streamer;
    localparam int NC = 10;
    localparam int AB = 20;
    localparam int B  = 8;
    localparam int IW = 4;
    localparam int SH = 8;
    localparam int DC = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_en = 1'b0;
    logic [IW-1:0]        wr_addr = '0;
    logic signed [AB-1:0] wr_data = '0;
    logic                 start = 1'b0;
    logic                 res_ack = 1'b0;
    logic                 busy;
    logic                 res_valid;
    logic [IW-1:0]        result_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int model [NC];

    score_streamer_if #(.BIT(B), .IDX_W(IW)) sif ();

    score_streamer #(
        .NUM_CLASS(NC), .ACC_BIT(AB), .BIT(B), .IDX_W(IW), .SHIFT(SH), .DRAIN_CYC(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .strm       (sif),
        .busy       (busy),
        .res_valid  (res_valid),
        .result_idx (result_idx),
        .res_ack    (res_ack)
    );

    always #5 clk = ~clk;

    // Behavioural argmax comparator: load on first, replace on strictly greater.
    logic signed [B-1:0] best_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_r      <= '0;
            sif.cmp_idx <= '0;
        end else if (sif.s_valid && (sif.s_first || (sif.s_data > best_r))) begin
            best_r      <= sif.s_data;
            sif.cmp_idx <= sif.s_idx;
        end
    end

    // Reference requantization: floor division by 2^SH, then clamp or wrap.
    function automatic int q_model(input int s);
        int d;
        int f;
        d = 1 << SH;
        if (s >= 0) f = s / d;
        else        f = -((-s + d - 1) / d);
`ifdef SCORE_STREAMER_SAT_EN
        if (f > 127)  f = 127;
        if (f < -128) f = -128;
`else
        f = ((f % 256) + 256) % 256;
        if (f >= 128) f = f - 256;
`endif
        return f;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_data"},  $signed(sif.s_data), 0);
        check({tag, "_s_valid"}, sif.s_valid, 0);
        check({tag, "_s_first"}, sif.s_first, 0);
        check({tag, "_s_last"},  sif.s_last, 0);
        check({tag, "_s_idx"},   sif.s_idx, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_res_vld"}, res_valid, 0);
        check({tag, "_res_idx"}, result_idx, 0);
    endtask

    task automatic write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = IW'(addr);
        wr_data = AB'(data);
        if (addr < NC) model[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    function automatic int rnd_score();
        logic signed [AB-1:0] r;
        r = AB'($urandom);
        return int'(r);
    endfunction

    task automatic do_ack(input int win);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        check("ack_clears", res_valid, 0);
        check("ack_idx_hold", result_idx, win);
    endtask

    // One run: optional write with start, optional write+start at inj_beat,
    // optional reset at abort_beat, optional acknowledge at the end.
    task automatic run(input int inj_beat, input int abort_beat, input bit ack,
                       input bit ws, input int ws_addr, input int ws_data, output int win);
        int expq [NC];
        if (ws) begin
            wr_en   = 1'b1;
            wr_addr = IW'(ws_addr);
            wr_data = AB'(ws_data);
            if (ws_addr < NC) model[ws_addr] = ws_data;
        end
        for (int i = 0; i < NC; i++) expq[i] = q_model(model[i]);
        win = 0;
        for (int i = 1; i < NC; i++) if (expq[i] > expq[win]) win = i;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int b = 0; b < NC; b++) begin
            check("beat_valid", sif.s_valid, 1);
            check("beat_data",  $signed(sif.s_data), expq[b]);
            check("beat_idx",   sif.s_idx, b);
            check("beat_first", sif.s_first, (b == 0) ? 1 : 0);
            check("beat_last",  sif.s_last, (b == NC - 1) ? 1 : 0);
            check("beat_busy",  busy, 1);
            if (b == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                tick();
                rst_n = 1'b1;
                for (int i = 0; i < NC; i++) model[i] = 0;
                return;
            end
            if (b == inj_beat) begin
                wr_en   = 1'b1;
                wr_addr = IW'(2);
                wr_data = AB'(rnd_score());
                start   = 1'b1;
                tick();
                wr_en = 1'b0;
                start = 1'b0;
            end else begin
                tick();
            end
        end
        for (int d = 0; d < DC; d++) begin
            check("drain_valid", sif.s_valid, 0);
            check("drain_last",  sif.s_last, 0);
            check("drain_busy",  busy, 1);
            check("drain_res",   res_valid, 0);
            tick();
        end
        check("res_valid", res_valid, 1);
        check("res_idx",   result_idx, win);
        check("res_busy",  busy, 0);
        if (ack) do_ack(win);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int win;
        int tp [NC];
        tp = '{1, 5, 3, -2, 9, 0, 4, 7, 2, 8};
        for (int i = 0; i < NC; i++) model[i] = 0;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("reset");

        // Known stream and argmax; result holds without ack
        for (int i = 0; i < NC; i++) write(i, 256 * tp[i]);
        run(-1, -1, 1'b0, 1'b0, 0, 0, win);
        check("tp_winner", result_idx, 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_idx", result_idx, 4);
        end
        do_ack(4);

        // Requantization boundaries
        write(0, 40000);
        write(1, -40000);
        run(-1, -1, 1'b1, 1'b0, 0, 0, win);

        // Write + start mid-stream are ignored; bank unchanged afterwards
        run(3, -1, 1'b1, 1'b0, 0, 0, win);
        run(-1, -1, 1'b1, 1'b0, 0, 0, win);

        // Start while a result is pending is ignored
        run(-1, -1, 1'b0, 1'b0, 0, 0, win);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("pend_no_stream", sif.s_valid, 0);
            check("pend_no_busy", busy, 0);
            check("pend_res", res_valid, 1);
            tick();
        end
        do_ack(win);
        run(-1, -1, 1'b1, 1'b0, 0, 0, win);

        // Random score sets, random dropped addresses, start-with-write
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 8; w++) write(int'($urandom_range(0, 15)), rnd_score());
            run(-1, -1, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rnd_score(), win);
        end

        // Reset mid-run, then a clean run from the cleared bank
        run(-1, 5, 1'b1, 1'b0, 0, 0, win);
        check_all_zero("post_reset");
        run(-1, -1, 1'b1, 1'b0, 0, 0, win);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
